// File: rtl/prf_writeback_arbiter_pkg.sv
// prf_writeback_arbiter_pkg: shared widths and registered beat type for the PRF writeback arbiter.
// Default widths stand in for riscv_define.v when it is not part of the build.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 6
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NUM_WB_SRC
`define NUM_WB_SRC 4
`endif
package prf_writeback_arbiter_pkg;
  localparam int AW = `REG_ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_beat_t;
endpackage

// File: rtl/prf_writeback_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr_i.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);
  int k;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      k = (int'(ptr_i) + i) % NUM_SRC;
      if (!any_o && req_i[k]) begin
        gnt_o[k] = 1'b1;
        idx_o    = PTR_W'(k);
        any_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/prf_writeback_arbiter.sv
// prf_writeback_arbiter: round-robin collector of execution results onto one int and one fp PRF write port.
// Define PRF_WB_PERF_CNT_EN to add the perf_stall_cnt output.
module prf_writeback_arbiter
  import prf_writeback_arbiter_pkg::*;
#(
  parameter int NUM_SRC = `NUM_WB_SRC,
  parameter int PTR_W   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC-1:0]          src_is_fp,
  input  logic [NUM_SRC*AW-1:0]       src_addr,
  input  logic [NUM_SRC*DW-1:0]       src_data,
  output logic [AW-1:0]               i_rd_addr,
  output logic [DW-1:0]               i_rd_data,
  output logic                        i_rd_we,
  output logic [AW-1:0]               f_rd_addr,
  output logic [DW-1:0]               f_rd_data,
  output logic                        f_rd_we,
  output logic                        wk_int_valid,
  output logic [AW-1:0]               wk_int_tag,
  output logic                        wk_fp_valid,
  output logic [AW-1:0]               wk_fp_tag
`ifdef PRF_WB_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_stall_cnt
`endif
);
  logic [NUM_SRC-1:0] int_req, fp_req, int_gnt, fp_gnt;
  logic [PTR_W-1:0]   i_ptr_q, i_ptr_d, f_ptr_q, f_ptr_d, i_idx, f_idx;
  logic               i_any, f_any;
  wb_beat_t           i_q, i_d, f_q, f_d;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] g);
    return (g == PTR_W'(NUM_SRC-1)) ? '0 : g + 1'b1;
  endfunction

  // Flush masks requests so neither class grants and both pointers hold.
  assign int_req   = src_valid & ~src_is_fp & {NUM_SRC{~flush}};
  assign fp_req    = src_valid &  src_is_fp & {NUM_SRC{~flush}};
  assign src_ready = int_gnt | fp_gnt;

  rr_arbiter #(.NUM_SRC(NUM_SRC), .PTR_W(PTR_W)) u_int_arb (
    .req_i(int_req), .ptr_i(i_ptr_q), .gnt_o(int_gnt), .idx_o(i_idx), .any_o(i_any)
  );

  rr_arbiter #(.NUM_SRC(NUM_SRC), .PTR_W(PTR_W)) u_fp_arb (
    .req_i(fp_req), .ptr_i(f_ptr_q), .gnt_o(fp_gnt), .idx_o(f_idx), .any_o(f_any)
  );

  always_comb begin
    i_ptr_d = i_any ? ptr_next(i_idx) : i_ptr_q;
    f_ptr_d = f_any ? ptr_next(f_idx) : f_ptr_q;
    i_d = i_any ? {1'b1, src_addr[i_idx*AW +: AW], src_data[i_idx*DW +: DW]} : {1'b0, i_q.addr, i_q.data};
    f_d = f_any ? {1'b1, src_addr[f_idx*AW +: AW], src_data[f_idx*DW +: DW]} : {1'b0, f_q.addr, f_q.data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_ptr_q <= '0;
      f_ptr_q <= '0;
      i_q     <= '0;
      f_q     <= '0;
    end else begin
      i_ptr_q <= i_ptr_d;
      f_ptr_q <= f_ptr_d;
      i_q     <= i_d;
      f_q     <= f_d;
    end
  end

  assign i_rd_we      = i_q.we;
  assign i_rd_addr    = i_q.addr;
  assign i_rd_data    = i_q.data;
  assign f_rd_we      = f_q.we;
  assign f_rd_addr    = f_q.addr;
  assign f_rd_data    = f_q.data;
  assign wk_int_valid = i_q.we;
  assign wk_int_tag   = i_q.addr;
  assign wk_fp_valid  = f_q.we;
  assign wk_fp_tag    = f_q.addr;

`ifdef PRF_WB_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;
  always_comb perf_d = (|(src_valid & ~src_ready) && !flush) ? perf_q + 32'd1 : perf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else perf_q <= perf_d;
  end
  assign perf_stall_cnt = perf_q;
`endif
endmodule

// File: tb/tb_prf_writeback_arbiter.sv
// tb_prf_writeback_arbiter: directed plus randomized check of the writeback arbiter against a queue-level source model.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 6
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module tb_prf_writeback_arbiter;
  localparam int N  = 4;
  localparam int AW = `REG_ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [N-1:0] src_valid, src_ready, src_is_fp;
  logic [N*AW-1:0] src_addr;
  logic [N*DW-1:0] src_data;
  logic [AW-1:0] i_rd_addr, f_rd_addr, wk_int_tag, wk_fp_tag;
  logic [DW-1:0] i_rd_data, f_rd_data;
  logic i_rd_we, f_rd_we, wk_int_valid, wk_fp_valid;
`ifdef PRF_WB_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
`endif

  prf_writeback_arbiter #(.NUM_SRC(N), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready), .src_is_fp(src_is_fp),
    .src_addr(src_addr), .src_data(src_data),
    .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data), .i_rd_we(i_rd_we),
    .f_rd_addr(f_rd_addr), .f_rd_data(f_rd_data), .f_rd_we(f_rd_we),
    .wk_int_valid(wk_int_valid), .wk_int_tag(wk_int_tag),
    .wk_fp_valid(wk_fp_valid), .wk_fp_tag(wk_fp_tag)
`ifdef PRF_WB_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Pending result held by each source until it is accepted.
  bit            v[N];
  bit            fp[N];
  logic [AW-1:0] ad[N];
  logic [DW-1:0] da[N];
  int            iptr, fptr;
  bit            e_iwe, e_fwe;
  logic [AW-1:0] e_iaddr, e_faddr;
  logic [DW-1:0] e_idata, e_fdata;
  int unsigned   e_perf;
  logic [N-1:0]  seen_ready;

  function automatic int pick(input bit want_fp, input int ptr);
    for (int o = 0; o < N; o++) begin
      int k = (ptr + o) % N;
      if (v[k] && fp[k] == want_fp) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    iptr = 0; fptr = 0; e_iwe = 0; e_fwe = 0;
    e_iaddr = '0; e_faddr = '0; e_idata = '0; e_fdata = '0; e_perf = 0;
    for (int k = 0; k < N; k++) v[k] = 0;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      src_valid[k] = v[k];
      src_is_fp[k] = fp[k];
      src_addr[k*AW +: AW] = ad[k];
      src_data[k*DW +: DW] = da[k];
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_iwe"}, i_rd_we, e_iwe);
    check({tag, "_iaddr"}, i_rd_addr, e_iaddr);
    check({tag, "_idata"}, i_rd_data, e_idata);
    check({tag, "_fwe"}, f_rd_we, e_fwe);
    check({tag, "_faddr"}, f_rd_addr, e_faddr);
    check({tag, "_fdata"}, f_rd_data, e_fdata);
    check({tag, "_wkiv"}, wk_int_valid, e_iwe);
    check({tag, "_wkit"}, wk_int_tag, e_iaddr);
    check({tag, "_wkfv"}, wk_fp_valid, e_fwe);
    check({tag, "_wkft"}, wk_fp_tag, e_faddr);
`ifdef PRF_WB_PERF_CNT_EN
    check({tag, "_perf"}, perf_stall_cnt, e_perf);
`endif
  endtask

  // One clock: present sources, check grants, advance model, check registered beat.
  task automatic step(input string tag, input bit fl);
    int ig, fg;
    logic [N-1:0] er;
    drive();
    flush = fl;
    #2;
    ig = fl ? -1 : pick(0, iptr);
    fg = fl ? -1 : pick(1, fptr);
    er = '0;
    if (ig >= 0) er[ig] = 1'b1;
    if (fg >= 0) er[fg] = 1'b1;
    seen_ready = src_ready;
    check({tag, "_ready"}, src_ready, er);
    for (int k = 0; k < N; k++)
      if (!fl && v[k] && !er[k]) begin e_perf++; break; end
    @(posedge clk);
    #1;
    e_iwe = (ig >= 0);
    e_fwe = (fg >= 0);
    if (ig >= 0) begin e_iaddr = ad[ig]; e_idata = da[ig]; iptr = (ig + 1) % N; v[ig] = 0; end
    if (fg >= 0) begin e_faddr = ad[fg]; e_fdata = da[fg]; fptr = (fg + 1) % N; v[fg] = 0; end
    flush = 1'b0;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    drive();
    check_outputs(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_src(input int k, input bit isfp, input logic [AW-1:0] a, input logic [DW-1:0] d);
    v[k] = 1; fp[k] = isfp; ad[k] = a; da[k] = d;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin fp[k] = 0; ad[k] = '0; da[k] = '0; end
    model_reset();
    drive();
    @(posedge clk);
    #1;
    check_outputs("por");
    rst_n = 1'b1;

    // Mid-run reset with a live int beat, then first transfer after release.
    set_src(2, 0, 6'd3, 32'h77);
    step("pre_rst", 0);
    check("pre_rst_we", i_rd_we, 1);
    do_reset("mid_rst");
    set_src(0, 0, 6'd5, 32'hAA);
    step("rst_first", 0);
    check("rst_first_addr", i_rd_addr, 5);
    check("rst_first_data", i_rd_data, 32'hAA);

    // Fairness: all four int sources re-present every cycle.
    do_reset("fair_rst");
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < N; k++) set_src(k, 0, AW'(10 + k), DW'(32'h100 + k));
      step("fair", 0);
      check("fair_seq", i_rd_addr, AW'(10 + (c % 4)));
    end
    for (int k = 0; k < N; k++) v[k] = 0;

    // Dual class in one cycle (int pointer 1, fp pointer 0 here).
    set_src(1, 0, 6'd7, 32'h11);
    set_src(2, 1, 6'd9, 32'h22);
    step("dual", 0);
    check("dual_ready", seen_ready, 4'b0110);
    check("dual_itag", wk_int_tag, 7);
    check("dual_ftag", wk_fp_tag, 9);

    // Flush blocks grants; int pointer (2) survives it.
    set_src(0, 0, 6'd30, 32'h30);
    set_src(3, 0, 6'd33, 32'h33);
    step("flush", 1);
    check("flush_ready", seen_ready, 0);
    check("flush_we", i_rd_we, 0);
    step("post_flush", 0);
    check("post_flush_addr", i_rd_addr, 33);
    step("drain0", 0);

    // Backpressure: int pointer is 1, so src1 wins and src0 holds its data.
    set_src(0, 0, 6'd1, 32'h55);
    set_src(1, 0, 6'd2, 32'h66);
    step("hold_a", 0);
    check("hold_a_data", i_rd_data, 32'h66);
    step("hold_b", 0);
    check("hold_b_data", i_rd_data, 32'h55);

`ifdef PRF_WB_PERF_CNT_EN
    do_reset("perf_rst");
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 3; k++) set_src(k, 0, AW'(k), DW'(k));
      step("perf", 0);
    end
    check("perf_four", perf_stall_cnt, 4);
    for (int k = 0; k < N; k++) v[k] = 0;
`endif

    // Randomized traffic; sources hold a pending result until accepted.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++)
        if (!v[k] && $urandom_range(2) == 0)
          set_src(k, 1'($urandom_range(1)), AW'($urandom), DW'($urandom));
      step("rand", $urandom_range(7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/prf_writeback_arbiter.md
Name: prf_writeback_arbiter

Overview:
- Write-side producer for the physical register file.
- Collects results from NUM_SRC execution units over valid/ready handshakes.
- Arbitrates round-robin onto one integer write port and one float write port per cycle.
- Outputs are registered and drive the PRF rd_addr/rd_data/rd_we inputs directly. The same registered beat is broadcast as a wakeup tag for the issue queues.

Parameters:
- NUM_SRC, 4, number of result sources (execution units), 2..8.
- PTR_W, 2, width of the round-robin pointer; equals clog2(NUM_SRC).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush: block all grants this cycle.
- src_valid  in  NUM_SRC  per-source result valid.
- src_ready  out  NUM_SRC  per-source grant (combinational from src_valid, flush, pointers).
- src_is_fp  in  NUM_SRC  1 = float destination, 0 = int destination.
- src_addr  in  NUM_SRC*`REG_ADDR_WIDTH  flattened destination preg; source k at [k*W +: W].
- src_data  in  NUM_SRC*`DATA_WIDTH  flattened result data.
- i_rd_addr  out  `REG_ADDR_WIDTH  int PRF write address.
- i_rd_data  out  `DATA_WIDTH  int PRF write data.
- i_rd_we  out  1  int PRF write enable.
- f_rd_addr  out  `REG_ADDR_WIDTH  float PRF write address.
- f_rd_data  out  `DATA_WIDTH  float PRF write data.
- f_rd_we  out  1  float PRF write enable.
- wk_int_valid  out  1  int wakeup valid (equals i_rd_we).
- wk_int_tag  out  `REG_ADDR_WIDTH  int wakeup tag (equals i_rd_addr).
- wk_fp_valid  out  1  fp wakeup valid (equals f_rd_we).
- wk_fp_tag  out  `REG_ADDR_WIDTH  fp wakeup tag (equals f_rd_addr).

Behaviour:
- Single clock domain: clk. Reset is rst_n, asynchronous active-low.
- Reset values:
  - All outputs 0.
  - Both round-robin pointers 0.
- Request formation each cycle:
  - int_req[k] = src_valid[k] & ~src_is_fp[k].
  - fp_req[k] = src_valid[k] & src_is_fp[k].
- Grant:
  - The int and fp classes arbitrate independently.
  - Each class grants at most one source: the first requester at or after its pointer, searching upward modulo NUM_SRC.
  - src_ready[k] = grant_int[k] | grant_fp[k].
  - A source is never granted twice in one cycle.
  - A transfer occurs when src_valid & src_ready.
- Pointer update: on an int grant to source g, int pointer <= (g+1) mod NUM_SRC; the fp pointer updates the same way. A pointer holds when its class has no grant.
- Latency: a transfer at edge t appears on the outputs from t until t+1. The PRF captures it at edge t+1, so there is one-cycle register latency.
- Output registers:
  - i_rd_we <= |grant_int; when set, i_rd_addr/i_rd_data load the granted source's fields.
  - With no grant, addr/data hold their previous values and we = 0.
  - The f_* registers behave the same for the fp class.
- Source rule: a source holds valid/addr/data stable until ready. The arbiter does not check this rule.
- flush=1:
  - All src_ready = 0; no grants; we outputs 0 next cycle; pointers hold.
  - A beat already registered before the flush still completes its write.
- Simultaneous events:
  - One int source and one fp source are both granted in the same cycle.
  - Two requesters of the same class are serialized by the pointer.
- Reset mid-operation: registered beats are discarded with we = 0. Sources must re-present their results.
- No storage beyond the output stage, so full/empty conditions do not apply. Backpressure is expressed only through src_ready.

Optional Feature:
- Macro: PRF_WB_PERF_CNT_EN.
- Defined:
  - Adds output port perf_stall_cnt, 32 bits.
  - Counts cycles where (src_valid & ~src_ready) != 0 and flush = 0.
  - Reset value 0; wraps modulo 2^32.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- riscv_define.v:
  - Continues to supply `REG_ADDR_WIDTH and `DATA_WIDTH.
  - Adds `NUM_WB_SRC (default source count), used by the instantiating core.
- One sub-module: rr_arbiter.
  - Parameters NUM_SRC, PTR_W.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational, instantiated twice (int and fp).
  - The pointer registers live in prf_writeback_arbiter.

Test Plan:
- Reset: assert rst_n=0 mid-run with i_rd_we=1 -> all outputs 0 immediately; after release, first int request from source 0 (addr 5, data 0xAA) -> i_rd_we=1, i_rd_addr=5, i_rd_data=0xAA one cycle later.
- Fairness: sources 0..3 all int, valid every cycle, addrs 10..13 -> grants 0,1,2,3,0 over consecutive cycles; i_rd_addr sequence 10,11,12,13,10; no source starves.
- Dual class: src1 int (addr 7, data 0x11) and src2 fp (addr 9, data 0x22) in same cycle -> both ready; next cycle i_rd_we=1/addr 7 and f_rd_we=1/addr 9; wk_int_tag=7, wk_fp_tag=9.
- Flush: flush=1 with src0 and src3 valid -> src_ready=0, we outputs 0 next cycle, pointers unchanged; flush=0 -> grant resumes at the saved pointer.
- Hold/backpressure: src0 and src1 int valid with int pointer=1 -> src1 granted, src0 held (data 0x55 stable); next cycle src0 granted, i_rd_data=0x55.
- PRF_WB_PERF_CNT_EN: 3 int sources valid for 4 cycles -> perf_stall_cnt=4; without the macro, the port is absent and the build is clean.
